// File: rtl/alarm_pkg.sv
// Shared state encoding for the alarm arming controller.
// Codes 5-7 are never produced and are treated as illegal by the FSM.
package alarm_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

endpackage

// File: rtl/alarm_arm_ctrl_if.sv
// Keypad/sensor inputs and alarm-logic outputs of the arming controller.
// master = front end / consumer side, slave = the controller itself.
interface alarm_arm_ctrl_if;
  import alarm_pkg::*;

  logic            arm_req;
  logic            disarm_req;
  logic            panic;
  logic            window;
  logic            door;
  logic            garage;
  logic            enable;
  logic            exiting;
  logic            alarm;
  logic            siren;
  logic            arm_fail;
  logic [ST_W-1:0] state;

  modport master (
    output arm_req, disarm_req, panic, window, door, garage,
    input  enable, exiting, alarm, siren, arm_fail, state
  );

  modport slave (
    input  arm_req, disarm_req, panic, window, door, garage,
    output enable, exiting, alarm, siren, arm_fail, state
  );

endinterface

// File: rtl/alarm_arm_ctrl_delay_timer.sv
// Loadable down-counter that saturates at zero; zero flag is decoded from the register.
// Load wins over dec; no backpressure, one update per clock.
module delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_arm_ctrl.sv
// Arming FSM: keypad/sensor inputs to enable/exiting/alarm/siren, with timed exit, entry and siren.
// All outputs registered, one-cycle response to inputs; no backpressure.
module alarm_arm_ctrl
  import alarm_pkg::*;
#(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  alarm_arm_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYCLES - 1);

  state_t           state_q, state_nxt;
  logic             enable_q, exiting_q, alarm_q;
  logic             siren_q, siren_nxt;
  logic             arm_fail_q, arm_fail_nxt;
  logic             dly_load, dly_dec, dly_zero;
  logic [CNT_W-1:0] dly_val;
  logic             sir_load, sir_dec, sir_zero;

  // Exit and entry delays never overlap, so they share one counter.
  delay_timer #(.CNT_W(CNT_W)) u_dly_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  delay_timer #(.CNT_W(CNT_W)) u_sir_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (sir_load),
    .load_val (SIREN_LD),
    .dec      (sir_dec),
    .zero     (sir_zero)
  );

  always_comb begin
    state_nxt    = state_q;
    siren_nxt    = siren_q;
    arm_fail_nxt = 1'b0;
    dly_load     = 1'b0;
    dly_val      = EXIT_LD;
    dly_dec      = 1'b0;
    sir_load     = 1'b0;
    sir_dec      = 1'b0;

    if (bus.panic) begin
      state_nxt = ST_ALARM;
      siren_nxt = 1'b1;
      sir_load  = 1'b1;
    end else if (bus.disarm_req) begin
      state_nxt = ST_DISARMED;
      siren_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (bus.arm_req) begin
            if (bus.window) begin
              arm_fail_nxt = 1'b1;
            end else begin
              state_nxt = ST_EXIT_DELAY;
              dly_load  = 1'b1;
              dly_val   = EXIT_LD;
            end
          end
        end
        ST_EXIT_DELAY: begin
          if (dly_zero) state_nxt = ST_ARMED;
          else          dly_dec   = 1'b1;
        end
        ST_ARMED: begin
          if (bus.window) begin
            state_nxt = ST_ALARM;
            siren_nxt = 1'b1;
            sir_load  = 1'b1;
          end else if (bus.door || bus.garage) begin
            state_nxt = ST_ENTRY_DELAY;
            dly_load  = 1'b1;
            dly_val   = ENTRY_LD;
          end
        end
        ST_ENTRY_DELAY: begin
          if (bus.window || dly_zero) begin
            state_nxt = ST_ALARM;
            siren_nxt = 1'b1;
            sir_load  = 1'b1;
          end else begin
            dly_dec = 1'b1;
          end
        end
        ST_ALARM: begin
          // Siren covers the cycle the timer reads 0, then drops while alarm holds.
          if (sir_zero) siren_nxt = 1'b0;
          else          sir_dec   = 1'b1;
        end
        default: begin
          state_nxt = ST_DISARMED;
          siren_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DISARMED;
      enable_q   <= 1'b0;
      exiting_q  <= 1'b0;
      alarm_q    <= 1'b0;
      siren_q    <= 1'b0;
      arm_fail_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      enable_q   <= (state_nxt != ST_DISARMED);
      exiting_q  <= (state_nxt == ST_EXIT_DELAY);
      alarm_q    <= (state_nxt == ST_ALARM);
      siren_q    <= siren_nxt;
      arm_fail_q <= arm_fail_nxt;
    end
  end

  assign bus.state    = state_q;
  assign bus.enable   = enable_q;
  assign bus.exiting  = exiting_q;
  assign bus.alarm    = alarm_q;
  assign bus.siren    = siren_q;
  assign bus.arm_fail = arm_fail_q;

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// Scoreboard bench for alarm_arm_ctrl: directed steps push expected outputs,
// a monitor pops and compares after every rising edge (or on an async-reset probe).
module tb_alarm_arm_ctrl;
  import alarm_pkg::*;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       en;
    logic       ex;
    logic       al;
    logic       si;
    logic       af;
  } exp_t;

  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_ARM  = 6'b100000;
  localparam logic [5:0] I_DIS  = 6'b010000;
  localparam logic [5:0] I_PAN  = 6'b001000;
  localparam logic [5:0] I_WIN  = 6'b000100;
  localparam logic [5:0] I_DOOR = 6'b000010;
  localparam logic [5:0] I_GAR  = 6'b000001;

  logic clk;
  logic rst;
  alarm_arm_ctrl_if bus();

  alarm_arm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  event smp_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    -> smp_ev;
  end

  task automatic chk(input string nm, input string fld, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0d expected=%0d at t=%0t", nm, fld, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input logic [2:0] st, input logic si, input logic af);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.en   = (st != 3'd0);
    e.ex   = (st == 3'd1);
    e.al   = (st == 3'd4);
    e.si   = si;
    e.af   = af;
    sb_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [5:0] iv, input logic [2:0] st,
                      input logic si, input logic af);
    @(negedge clk);
    {bus.arm_req, bus.disarm_req, bus.panic, bus.window, bus.door, bus.garage} = iv;
    push(nm, st, si, af);
  endtask

  // Arm, run the full exit delay while poking ignored inputs, land in ARMED.
  task automatic arm_and_exit(input string tag);
    logic [5:0] iv;
    step({tag, "_arm"}, I_ARM, 3'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      if (i % 2 == 1)  iv = I_DOOR;
      else if (i == 6) iv = I_ARM | I_GAR;
      else if (i == 8) iv = I_WIN;
      else             iv = I_NONE;
      step({tag, "_exit"}, iv, 3'd1, 1'b0, 1'b0);
    end
    step({tag, "_armed"}, I_NONE, 3'd2, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(smp_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "state",    bus.state,               e.st);
        chk(e.name, "enable",   {2'b00, bus.enable},     {2'b00, e.en});
        chk(e.name, "exiting",  {2'b00, bus.exiting},    {2'b00, e.ex});
        chk(e.name, "alarm",    {2'b00, bus.alarm},      {2'b00, e.al});
        chk(e.name, "siren",    {2'b00, bus.siren},      {2'b00, e.si});
        chk(e.name, "arm_fail", {2'b00, bus.arm_fail},   {2'b00, e.af});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    {bus.arm_req, bus.disarm_req, bus.panic, bus.window, bus.door, bus.garage} = I_NONE;
    step("rst_hold", I_NONE, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("idle", I_NONE, 3'd0, 1'b0, 1'b0);
    step("idle", I_NONE, 3'd0, 1'b0, 1'b0);

    // Arm refused with window open
    step("arm_refused", I_ARM | I_WIN, 3'd0, 1'b0, 1'b1);
    step("af_clear", I_NONE, 3'd0, 1'b0, 1'b0);

    // Arm + disarm together: disarm wins
    step("arm_dis", I_ARM | I_DIS, 3'd0, 1'b0, 1'b0);
    step("arm_dis_win", I_ARM | I_DIS | I_WIN, 3'd0, 1'b0, 1'b0);

    // Disarm during exit delay
    step("ex_arm", I_ARM, 3'd1, 1'b0, 1'b0);
    step("ex_dis", I_DIS, 3'd0, 1'b0, 1'b0);

    // Entry delay cancelled by disarm
    arm_and_exit("e1");
    step("e1_entry", I_DOOR, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("e1_wait", I_NONE, 3'd3, 1'b0, 1'b0);
    step("e1_dis", I_DIS, 3'd0, 1'b0, 1'b0);

    // Entry delay expiring: alarm 8 edges after entering ENTRY_DELAY
    arm_and_exit("e2");
    step("e2_entry", I_GAR, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("e2_wait", I_NONE, 3'd3, 1'b0, 1'b0);
    step("e2_alarm", I_NONE, 3'd4, 1'b1, 1'b0);
    step("e2_dis", I_DIS, 3'd0, 1'b0, 1'b0);

    // Window while armed, siren timeout, panic reload, disarm
    arm_and_exit("sr");
    step("sr_win", I_WIN, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) step("sr_on", I_NONE, 3'd4, 1'b1, 1'b0);
    step("sr_off", I_NONE, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("sr_held", I_NONE, 3'd4, 1'b0, 1'b0);
    step("sr_panic", I_PAN, 3'd4, 1'b1, 1'b0);
    step("sr_reload", I_NONE, 3'd4, 1'b1, 1'b0);
    step("sr_dis_pan", I_DIS | I_PAN, 3'd4, 1'b1, 1'b0);
    step("sr_dis", I_DIS, 3'd0, 1'b0, 1'b0);

    // Panic beats disarm from DISARMED
    step("pn", I_PAN | I_DIS, 3'd4, 1'b1, 1'b0);
    step("pn_hold", I_NONE, 3'd4, 1'b1, 1'b0);
    step("pn_dis", I_DIS, 3'd0, 1'b0, 1'b0);

    // Async reset mid exit delay (timer at 9)
    step("rr_arm", I_ARM, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("rr_exit", I_NONE, 3'd1, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    push("rst_async", 3'd0, 1'b0, 1'b0);
    #1;
    -> smp_ev;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("rst_idle", I_NONE, 3'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
